// File: rtl/ads_spi_pkg.sv
// Shared types and frame constants for the ADS SPI responder.
// The frame is a 16-bit command phase followed by a 16-bit response phase.
package ads_spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int CMD_START_BIT = 15;
    localparam int CMD_CH_LSB    = 12;
    localparam int CMD_CH_W      = 2;
    localparam int FRAME_BITS    = 32;
    localparam int CMD_BITS      = FRAME_BITS / 2;
    localparam int CNT_W         = $clog2(FRAME_BITS);

endpackage

// File: rtl/ads_spi_responder_if.sv
// SPI pin bundle between the ADS reader (master) and the responder (slave).
interface ads_spi_responder_if;
    logic cs_n;
    logic sclk;
    logic mosi;
    logic miso;

    modport master (output cs_n, output sclk, output mosi, input miso);
    modport slave  (input cs_n, input sclk, input mosi, output miso);
endinterface

// File: rtl/ads_spi_sync_edge.sv
// One SPI pin: SYNC_STAGES-deep synchronizer plus one edge-detect flop.
// Level and edges are valid together, two clocks after the pin moves.
module ads_spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pin,
    output logic o_lvl,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= {SYNC_STAGES{RST_VAL}};
            r_prev <= RST_VAL;
        end else begin
            r_sync <= SYNC_STAGES'({r_sync, i_pin});
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_lvl  = r_sync[SYNC_STAGES-1];
    assign o_rise =  o_lvl & ~r_prev;
    assign o_fall = ~o_lvl &  r_prev;

endmodule

// File: rtl/ads_spi_responder.sv
// SPI slave emulating the ADS ADC serial port: takes a 16-bit command, then
// returns the addressed channel's held sample over the next 16 SCLK periods.
module ads_spi_responder
    import ads_spi_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int CMD_W       = 16,
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    ads_spi_responder_if.slave     spi,
    input  logic [N_CH*DATA_W-1:0] ch_data,
    input  logic [N_CH-1:0]        ch_data_en,
    output logic                   frame_done,
    output logic                   cmd_err,
    output logic                   frame_abort,
    output logic [CMD_CH_W-1:0]    last_ch
);

    logic w_cs_lvl, w_cs_rise, w_cs_fall;
    logic w_sclk_lvl, w_sclk_rise_raw, w_sclk_fall_raw;
    logic w_mosi_lvl, w_mosi_rise, w_mosi_fall;
    logic w_unused;

    ads_spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .i_pin(spi.cs_n),
        .o_lvl(w_cs_lvl), .o_rise(w_cs_rise), .o_fall(w_cs_fall));

    ads_spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .i_pin(spi.sclk),
        .o_lvl(w_sclk_lvl), .o_rise(w_sclk_rise_raw), .o_fall(w_sclk_fall_raw));

    ads_spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .i_pin(spi.mosi),
        .o_lvl(w_mosi_lvl), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall));

    assign w_unused = &{1'b0, w_sclk_lvl, w_mosi_rise, w_mosi_fall};

    // SCLK activity only counts while chip select is held low.
    logic w_sclk_rise, w_sclk_fall;
    assign w_sclk_rise = w_sclk_rise_raw & ~w_cs_lvl;
    assign w_sclk_fall = w_sclk_fall_raw & ~w_cs_lvl;

    state_e                r_state, w_state_nxt;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic [CMD_W-2:0]      r_cmd;
    logic [DATA_W-1:0]     r_resp;
    logic                  r_miso;
    logic                  r_frame_done, r_cmd_err, r_frame_abort;
    logic [CMD_CH_W-1:0]   r_last_ch;
    logic [DATA_W-1:0]     r_hold [N_CH];

    // r_cmd holds command bits 15..1 when the 16th bit arrives on mosi.
    logic                w_start;
    logic [CMD_CH_W-1:0] w_ch;
    assign w_start = r_cmd[CMD_START_BIT-1];
    assign w_ch    = r_cmd[CMD_CH_LSB-1 +: CMD_CH_W];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_cs_fall) w_state_nxt = ST_CMD;
            ST_CMD: begin
                if (w_cs_rise)
                    w_state_nxt = ST_IDLE;
                else if (w_sclk_rise && r_bit_cnt == CNT_W'(CMD_BITS-1))
                    w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (w_cs_rise)
                    w_state_nxt = ST_IDLE;
                else if (w_sclk_rise && r_bit_cnt == CNT_W'(FRAME_BITS-1))
                    w_state_nxt = ST_DONE;
            end
            ST_DONE: if (w_cs_rise) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    logic w_snap, w_last, w_abort, w_shift;
    always_comb begin
        w_snap  = 1'b0;
        w_last  = 1'b0;
        w_abort = 1'b0;
        w_shift = 1'b0;
        case (r_state)
            ST_CMD: begin
                w_abort = w_cs_rise;
                w_snap  = !w_cs_rise && w_sclk_rise && r_bit_cnt == CNT_W'(CMD_BITS-1);
            end
            ST_DATA: begin
                w_abort = w_cs_rise;
                w_last  = !w_cs_rise && w_sclk_rise && r_bit_cnt == CNT_W'(FRAME_BITS-1);
                w_shift = !w_cs_rise && w_sclk_fall;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_bit_cnt <= '0;
        else if (r_state == ST_IDLE || r_state == ST_DONE || w_cs_rise)
            r_bit_cnt <= '0;
        else if (w_sclk_rise)
            r_bit_cnt <= r_bit_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_cmd <= '0;
        else if (r_state == ST_IDLE)
            r_cmd <= '0;
        else if (r_state == ST_CMD && w_sclk_rise)
            r_cmd <= {r_cmd[CMD_W-3:0], w_mosi_lvl};
    end

    // Snapshot reads the hold register before any same-clock strobe lands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_resp <= '0;
            r_miso <= 1'b0;
        end else begin
            if (w_snap)
                r_resp <= w_start ? r_hold[w_ch] : '0;
            else if (w_shift)
                r_resp <= {r_resp[DATA_W-2:0], 1'b0};

            if (w_state_nxt != ST_DATA)
                r_miso <= 1'b0;
            else if (w_shift)
                r_miso <= r_resp[DATA_W-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_frame_done  <= 1'b0;
            r_cmd_err     <= 1'b0;
            r_frame_abort <= 1'b0;
            r_last_ch     <= '0;
        end else begin
            r_frame_done  <= w_last;
            r_cmd_err     <= w_snap & ~w_start;
            r_frame_abort <= w_abort;
            if (w_snap && w_start)
                r_last_ch <= w_ch;
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_hold
        always_ff @(posedge clk or negedge rst) begin
            if (!rst)
                r_hold[k] <= '0;
            else if (ch_data_en[k])
                r_hold[k] <= ch_data[k*DATA_W +: DATA_W];
        end
    end

    assign spi.miso    = r_miso;
    assign frame_done  = r_frame_done;
    assign cmd_err     = r_cmd_err;
    assign frame_abort = r_frame_abort;
    assign last_ch     = r_last_ch;

endmodule

// File: tb/tb_ads_spi_responder.sv
// Bench for ads_spi_responder: a master driver with a reference model pushes
// the expected outcome of each frame; a monitor observes the pins and pulses.
module tb_ads_spi_responder;

    localparam int HALF = 4;

    typedef struct packed {
        logic        done;
        logic        err;
        logic [15:0] word;
        logic [1:0]  ch;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [63:0] ch_data;
    logic [3:0]  ch_data_en;
    logic        frame_done, cmd_err, frame_abort;
    logic [1:0]  last_ch;

    ads_spi_responder_if spi();

    ads_spi_responder dut (
        .clk(clk), .rst(rst), .spi(spi),
        .ch_data(ch_data), .ch_data_en(ch_data_en),
        .frame_done(frame_done), .cmd_err(cmd_err),
        .frame_abort(frame_abort), .last_ch(last_ch));

    initial clk = 1'b0;
    always #10 clk = ~clk;

    exp_t        exp_q[$];
    logic [15:0] hold_m [4];
    logic [1:0]  last_m;
    bit          stim_done = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
        end
    endtask

    // ---------------- monitor ----------------
    int          bitn = 0, errs = 0, miso_cd = 0, cyc = 0;
    logic [15:0] rx = '0;
    logic        rx_cmd = 1'b0, extra = 1'b0;
    logic        cs_prev = 1'b1, sclk_prev = 1'b0;
    exp_t        e_cur;

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            chk("reset_outputs", {26'd0, spi.miso, frame_done, cmd_err, frame_abort, last_ch}, 32'd0);
            bitn = 0; errs = 0; miso_cd = 0; rx = '0; rx_cmd = 1'b0; extra = 1'b0;
        end else begin
            if (!spi.cs_n && cs_prev) begin
                bitn = 0; errs = 0; rx = '0; rx_cmd = 1'b0; extra = 1'b0;
            end
            if (spi.sclk && !sclk_prev && !spi.cs_n) begin
                if (bitn < 16)      rx_cmd = rx_cmd | spi.miso;
                else if (bitn < 32) rx = {rx[14:0], spi.miso};
                else                extra = extra | spi.miso;
                bitn++;
            end
            if (cmd_err) errs++;
            if (frame_done || frame_abort) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL spurious_pulse: got done=%0b abort=%0b expected none at %0t",
                             frame_done, frame_abort, $time);
                end else begin
                    e_cur = exp_q.pop_front();
                    chk("frame_kind", {31'd0, frame_done}, {31'd0, e_cur.done});
                    chk("cmd_err_count", errs, {31'd0, e_cur.err});
                    chk("last_ch", {30'd0, last_ch}, {30'd0, e_cur.ch});
                    if (e_cur.done) begin
                        chk("rx_word", {16'd0, rx}, {16'd0, e_cur.word});
                        chk("miso_in_cmd", {31'd0, rx_cmd}, 32'd0);
                    end
                end
            end
            if (spi.cs_n && !cs_prev) begin
                miso_cd = 3;
                if (bitn > 32) chk("miso_after_32", {31'd0, extra}, 32'd0);
            end else if (miso_cd > 0) begin
                miso_cd--;
                if (miso_cd == 0) chk("miso_after_cs_rise", {31'd0, spi.miso}, 32'd0);
            end
        end
        cs_prev   = spi.cs_n;
        sclk_prev = spi.sclk;
        if (stim_done || cyc > 60000) begin
            if (!stim_done) begin
                miscompares++;
                $display("FAIL timeout: got %0d cycles expected stimulus end", cyc);
            end
            chk("queue_drained", exp_q.size(), 32'd0);
            $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
            $finish;
        end
    end

    // ---------------- driver + reference model ----------------
    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_hold(input int k, input logic [15:0] v);
        ch_data[k*16 +: 16] = v;
        ch_data_en[k] = 1'b1;
        wclk(1);
        ch_data_en = '0;
        hold_m[k] = v;
    endtask

    // n SCLK periods; snap_ch>=0 strobes that channel on the snapshot clock.
    task automatic frame(input logic [15:0] cmd, input int n,
                         input int snap_ch, input logic [15:0] snap_val);
        exp_t e;
        logic [1:0] ch;
        ch = cmd[13:12];
        e.done = (n >= 32);
        e.err  = (n >= 16) && !cmd[15];
        e.word = cmd[15] ? hold_m[ch] : 16'h0000;
        if (n >= 16 && cmd[15]) last_m = ch;
        e.ch = last_m;
        exp_q.push_back(e);

        spi.cs_n = 1'b0;
        wclk(HALF);
        for (int i = 0; i < n; i++) begin
            spi.mosi = (i < 16) ? cmd[15-i] : 1'($urandom);
            wclk(HALF);
            spi.sclk = 1'b1;
            if (i == 15 && snap_ch >= 0) begin
                wclk(2);
                ch_data[snap_ch*16 +: 16] = snap_val;
                ch_data_en[snap_ch] = 1'b1;
                wclk(1);
                ch_data_en = '0;
                hold_m[snap_ch] = snap_val;
                wclk(HALF-3);
            end else begin
                wclk(HALF);
            end
            spi.sclk = 1'b0;
        end
        wclk(HALF);
        spi.cs_n = 1'b1;
        spi.mosi = 1'b0;
        wclk(6);
    endtask

    initial begin
        logic [15:0] cmd;
        int n, sc;
        spi.cs_n = 1'b1; spi.sclk = 1'b0; spi.mosi = 1'b0;
        ch_data = '0; ch_data_en = '0;
        for (int k = 0; k < 4; k++) hold_m[k] = '0;
        last_m = '0;
        rst = 1'b0;
        wclk(3);
        rst = 1'b1;
        wclk(5);

        // basic read of channel 2, then a START=0 command
        for (int k = 0; k < 4; k++) set_hold(k, 16'($urandom));
        set_hold(2, 16'hA5C3);
        frame(16'hA000, 32, -1, 16'h0);
        frame(16'h3000, 32, -1, 16'h0);

        // reset in the middle of a frame
        spi.cs_n = 1'b0;
        wclk(HALF);
        for (int i = 0; i < 10; i++) begin
            spi.mosi = 1'(16'hA000 >> (15-i));
            wclk(HALF); spi.sclk = 1'b1;
            wclk(HALF); spi.sclk = 1'b0;
        end
        rst = 1'b0;
        wclk(2);
        spi.cs_n = 1'b1; spi.mosi = 1'b0;
        wclk(3);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) hold_m[k] = '0;
        last_m = '0;
        wclk(20);

        // abort after 20 SCLK, then a clean read of channel 1
        set_hold(1, 16'($urandom) | 16'h0F0F);
        frame(16'h9000, 20, -1, 16'h0);
        frame(16'h9000, 32, -1, 16'h0);

        // strobe coincident with snapshot
        set_hold(1, 16'h00FF);
        frame(16'h9000, 32, 1, 16'h1234);
        frame(16'h9000, 32, -1, 16'h0);

        // SCLK overrun
        set_hold(3, 16'($urandom));
        frame(16'hB000, 40, -1, 16'h0);

        // randomized frames
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 1) == 1)
                set_hold($urandom_range(0, 3), 16'($urandom));
            cmd = 16'($urandom);
            n = ($urandom_range(0, 2) != 0) ? 32 : $urandom_range(0, 40);
            sc = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1;
            frame(cmd, n, sc, 16'($urandom));
        end

        wclk(20);
        stim_done = 1'b1;
    end

endmodule
